// File: rtl/rf_unit_if.sv
// rf_unit_if: register-file port bundle.
// Master drives addresses/data, slave returns read data.
interface rf_unit_if #(
  parameter int WIDTH = 32
);

  logic             rf_we;
  logic [4:0]       rf_wa;
  logic [WIDTH-1:0] rf_wd;
  logic [4:0]       rf_rna;
  logic [4:0]       rf_rnb;
  logic [WIDTH-1:0] rf_qa;
  logic [WIDTH-1:0] rf_qb;
  logic [4:0]       rf_dbg_a;
  logic [WIDTH-1:0] rf_dbg_q;
  logic [15:0]      rf_wcnt;

  modport master (
    output rf_we,
    output rf_wa,
    output rf_wd,
    output rf_rna,
    output rf_rnb,
    output rf_dbg_a,
    input  rf_qa,
    input  rf_qb,
    input  rf_dbg_q,
    input  rf_wcnt
  );

  modport slave (
    input  rf_we,
    input  rf_wa,
    input  rf_wd,
    input  rf_rna,
    input  rf_rnb,
    input  rf_dbg_a,
    output rf_qa,
    output rf_qb,
    output rf_dbg_q,
    output rf_wcnt
  );

endinterface

// File: rtl/rf_unit.sv
// rf_unit: 32 x WIDTH register file, r0 hardwired to zero.
// Two combinational read ports with optional write bypass.
module rf_unit #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input logic     clk,
  input logic     rst,
  rf_unit_if.slave bus
);

  logic [WIDTH-1:0] regs [32];
  logic [15:0]      wcnt;
  logic             commit;
  logic             fwd_a;
  logic             fwd_b;
  logic [WIDTH-1:0] qa;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] dq;

  // A write lands only outside reset and never on r0.
  always_comb begin
    commit = bus.rf_we && !rst &&
             (bus.rf_wa != 5'd0);
  end

  // Forward this cycle's write data to a matching read.
  always_comb begin
    fwd_a = (BYPASS != 0) && commit &&
            (bus.rf_rna == bus.rf_wa);
    fwd_b = (BYPASS != 0) && commit &&
            (bus.rf_rnb == bus.rf_wa);
  end

  // Storage update and committed-write counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      wcnt <= '0;
    end else if (commit) begin
      regs[bus.rf_wa] <= bus.rf_wd;
      wcnt            <= wcnt + 16'd1;
    end
  end

  // Read port A: zero for r0, else bypass or array.
  always_comb begin
    qa = regs[bus.rf_rna];
    if (bus.rf_rna == 5'd0) begin
      qa = '0;
    end else if (fwd_a) begin
      qa = bus.rf_wd;
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    qb = regs[bus.rf_rnb];
    if (bus.rf_rnb == 5'd0) begin
      qb = '0;
    end else if (fwd_b) begin
      qb = bus.rf_wd;
    end
  end

  // Debug port always shows the stored value.
  always_comb begin
    dq = regs[bus.rf_dbg_a];
    if (bus.rf_dbg_a == 5'd0) begin
      dq = '0;
    end
  end

  assign bus.rf_qa    = qa;
  assign bus.rf_qb    = qb;
  assign bus.rf_dbg_q = dq;
  assign bus.rf_wcnt  = wcnt;

endmodule

// File: tb/tb_rf_unit.sv
// tb_rf_unit: random + directed stimulus, queue scoreboard.
// Checks a bypassing and a non-bypassing instance.
module tb_rf_unit;

  localparam int W = 32;

  typedef struct {
    string          nm;
    logic [W-1:0]   qa1;
    logic [W-1:0]   qb1;
    logic [W-1:0]   qa0;
    logic [W-1:0]   qb0;
    logic [W-1:0]   dq;
    logic [15:0]    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  rf_unit_if #(.WIDTH(W)) b1 ();
  rf_unit_if #(.WIDTH(W)) b0 ();

  rf_unit #(.WIDTH(W), .BYPASS(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b1.slave)
  );

  rf_unit #(.WIDTH(W), .BYPASS(0)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(b0.slave)
  );

  always #5 clk = ~clk;

  logic [W-1:0] m [32];
  logic [15:0]  cnt;
  exp_t         sb [$];
  int           total = 0;
  int           passed = 0;

  task automatic check(
    input string nm, input string f,
    input logic [W-1:0] act,
    input logic [W-1:0] exp
  );
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s.%s got %h want %h",
                  nm, f, act, exp);
  endtask

  function automatic logic [W-1:0] model_rd(
    input logic [4:0] a, input bit byp,
    input logic r, input logic we,
    input logic [4:0] wa, input logic [W-1:0] wd
  );
    if (a == 0) return '0;
    if (byp && !r && we && wa != 0 && a == wa)
      return wd;
    return m[a];
  endfunction

  task automatic cyc(
    input logic r, input logic we,
    input logic [4:0] wa, input logic [W-1:0] wd,
    input logic [4:0] ra, input logic [4:0] rb,
    input logic [4:0] da, input bit chk,
    input string nm
  );
    exp_t e;
    rst = r;
    b1.rf_we = we;  b0.rf_we = we;
    b1.rf_wa = wa;  b0.rf_wa = wa;
    b1.rf_wd = wd;  b0.rf_wd = wd;
    b1.rf_rna = ra; b0.rf_rna = ra;
    b1.rf_rnb = rb; b0.rf_rnb = rb;
    b1.rf_dbg_a = da; b0.rf_dbg_a = da;
    if (chk) begin
      e.nm  = nm;
      e.qa1 = model_rd(ra, 1, r, we, wa, wd);
      e.qb1 = model_rd(rb, 1, r, we, wa, wd);
      e.qa0 = model_rd(ra, 0, r, we, wa, wd);
      e.qb0 = model_rd(rb, 0, r, we, wa, wd);
      e.dq  = model_rd(da, 0, r, we, wa, wd);
      e.cnt = cnt;
      sb.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m[i] = '0;
      cnt = '0;
    end else if (we && wa != 0) begin
      m[wa] = wd;
      cnt   = cnt + 16'd1;
    end
    #1;
  endtask

  // Monitor: compare both instances against the queue head.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.nm, "qa",   b1.rf_qa,    e.qa1);
      check(e.nm, "qb",   b1.rf_qb,    e.qb1);
      check(e.nm, "dbg",  b1.rf_dbg_q, e.dq);
      check(e.nm, "wcnt", {16'd0, b1.rf_wcnt},
            {16'd0, e.cnt});
      check(e.nm, "qa_nb",   b0.rf_qa,    e.qa0);
      check(e.nm, "qb_nb",   b0.rf_qb,    e.qb0);
      check(e.nm, "dbg_nb",  b0.rf_dbg_q, e.dq);
      check(e.nm, "wcnt_nb", {16'd0, b0.rf_wcnt},
            {16'd0, e.cnt});
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) m[i] = '0;
    cnt = '0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "");
    // reset state on every address
    for (int i = 0; i < 32; i++)
      cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i),
          1, "reset");
    // basic write/read
    cyc(0, 1, 5, 32'h0000000F, 5, 6, 5, 1, "wr5");
    cyc(0, 1, 6, 32'h8000000C, 5, 6, 6, 1, "wr6");
    cyc(0, 0, 0, 0, 5, 6, 6, 1, "rd56");
    // r0 writes are ignored
    cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, "r0w");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, "r0r");
    // bypass with equal read addresses
    cyc(0, 1, 7, 32'h1, 7, 7, 7, 1, "r7set");
    cyc(0, 1, 7, 32'h12345678, 7, 7, 7, 1, "byp");
    cyc(0, 0, 0, 0, 7, 7, 7, 1, "bypafter");
    // reset beats a simultaneous write
    cyc(0, 1, 9, 32'h11, 9, 9, 9, 1, "pre9");
    cyc(1, 1, 9, 32'hA5A5A5A5, 9, 9, 9, 1, "rstwr");
    cyc(0, 0, 0, 0, 9, 7, 9, 1, "rst9");
    // random traffic, occasional reset
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa, ra, rb;
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa
           : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ra
           : 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 1)), wa, $urandom,
          ra, rb, 5'($urandom_range(0, 31)),
          1, "rand");
    end
    // counter wrap
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "");
    for (int n = 0; n < 65536; n++)
      cyc(0, 1, 5'((n % 31) + 1), W'(n),
          3, 4, 5, (n % 8192) == 0, "wrapw");
    cyc(0, 0, 0, 0, 3, 4, 5, 1, "wrap0");
    cyc(0, 1, 12, 32'hC0FFEE, 12, 1, 12, 1, "wrap1w");
    cyc(0, 0, 0, 0, 12, 1, 12, 1, "wrap1");
    for (int k = 0; k < 8 && sb.size() > 0; k++)
      @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain left %0d want 0",
               sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
